bit_mem_ctrl: RTL and testbench
===============================

# bit_mem_ctrl

Controller that owns the single port of a 32×1-bit memory and shares it between NREQ requesters. After reset it sequences a full clear of the memory, writing 0 to every address. It then grants one request per cycle by round-robin arbitration and returns a registered response to the winning requester. It sits between the requesters and the bit memory; the memory keeps its combinational read (`mem_rdata` follows `mem_addr`) and its write on the clock edge.

## Interface
- `ADDR_W`, default 5: memory address width.
- `DEPTH`, default 1<<ADDR_W (32): number of bit cells.
- `NREQ`, default 2 (legal range 2..4): number of requesters.
- `clk`  in  1: single clock; all state updates on the posedge.
- `rst`  in  1: reset, asynchronous and active-high.
- `req_valid`  in  NREQ: request pending, one bit per requester.
- `req_ready`  out  NREQ: request accepted this cycle (at most one bit high).
- `req_we`  in  NREQ: 1 = write, 0 = read.
- `req_addr`  in  NREQ×ADDR_W: target address per requester.
- `req_wdata`  in  NREQ: write bit per requester.
- `rsp_valid`  out  NREQ: one-cycle response pulse to the requester accepted in the previous cycle.
- `rsp_rdata`  out  1: cell value captured at the accept edge.
- `init_done`  out  1: high once the clear sequence has completed.
- `mem_we`  out  1: memory write enable.
- `mem_addr`  out  ADDR_W: memory address.
- `mem_wdata`  out  1: memory write data.
- `mem_rdata`  in  1: memory combinational read data.

## Operation
- States are INIT and SERVE. Reset forces INIT, clear counter = 0, rr pointer = NREQ-1 (requester 0 has first priority).
- While `rst` is high, all outputs are 0: `req_ready`, `rsp_valid`, `rsp_rdata`, `init_done`, `mem_we`, `mem_addr`, `mem_wdata`.
- INIT:
  - Drives `mem_we`=1, `mem_addr`=counter, `mem_wdata`=0. The counter increments each cycle.
  - On the edge where counter==DEPTH-1, go to SERVE and set `init_done`<=1.
  - `req_ready` is 0 throughout INIT.
- SERVE:
  - The grant goes to the first requester with `req_valid`=1, searching from pointer+1 modulo NREQ.
  - `req_ready[g]` is driven combinationally in the same cycle. The requester must hold valid, we, addr and wdata stable until ready.
  - `mem_addr`/`mem_we`/`mem_wdata` come from the granted request. With no request: `mem_we`=0 and `mem_addr`=0.
  - On the accept edge: pointer<=g, `rsp_rdata`<=`mem_rdata`, `rsp_valid`<=onehot(g). Otherwise `rsp_valid`<=0.
- Reads and writes are read-before-write: a write's response carries the old cell value.
- `req_addr` ≥ DEPTH cannot occur at the default widths. With non-power-of-2 DEPTH, the address is used modulo 2^ADDR_W with no check.
- Reset asserted mid-INIT or mid-SERVE:
  - All state clears immediately (asynchronously).
  - In-flight responses are dropped, with no `rsp_valid` pulse.
  - The clear sequence restarts from address 0.

## Timing
- Clear latency: with cycle 0 = first cycle with `rst` low, the writes occupy cycles 0..DEPTH-1. `init_done`=1 and the first grant are possible from cycle DEPTH (32).
- Request accepted in cycle T → `rsp_valid` high for exactly cycle T+1 → memory write takes effect at the T/T+1 edge.
- Throughput is one request per cycle. Back-to-back grants may go to the same or different requesters.
- A write to A at T followed by a read of A at T+1 returns the new value.
- A requester that drops `req_valid` before ready loses nothing; no state is held for it.
- Under contention, each of K continuously requesting requesters is granted once per K cycles.

## Structure
- Package `bit_mem_pkg`:
  - ADDR_W, DEPTH, NREQ default constants.
  - `state_t` enum {INIT, SERVE}.
  - `req_t` struct {we, addr, wdata}.
- Sub-module `rr_arbiter`:
  - Inputs: NREQ request vector, pointer.
  - Outputs: one-hot grant, grant index.
  - Purely combinational. The pointer register stays in `bit_mem_ctrl`.
- The bench instantiates a 32×1 bit memory model behind the mem_* port.

## Test plan
- Release reset, hold `req_valid`=0 → `mem_we`=1 for exactly cycles 0..31 with addr 0..31 and wdata 0; `init_done` rises at cycle 32; afterwards every read returns 0.
- After init, req0 writes 1 to addr 31, then reads addr 31 → write response `rsp_rdata`=0 (old value); read response `rsp_rdata`=1; each `rsp_valid` is a single cycle, one cycle after ready.
- Both requesters hold valid for 6 cycles (req0 reads 5, req1 writes 1 to 5) → grants alternate 0,1,0,1,0,1 starting with req0; every read issued after the first write returns 1.
- Write addr 7 = 1 accepted at T, read addr 7 accepted at T+1 → read response at T+2 is 1.
- Assert `rst` at cycle 10 of INIT, then again one cycle after a SERVE accept → all outputs 0 immediately, no `rsp_valid` pulse, clear restarts at addr 0, and previously written 1s read back as 0.
- Assert `req_valid` during INIT → `req_ready` stays 0 until cycle 32; the request is then accepted in cycle 32.

Source files
------------

// File: rtl/bit_mem_pkg.sv
// Shared constants and types for the bit memory controller and its arbiter.
package bit_mem_pkg;

    localparam int DEF_ADDR_W = 5;
    localparam int DEF_DEPTH  = 1 << DEF_ADDR_W;
    localparam int DEF_NREQ   = 2;

    typedef enum logic {
        INIT  = 1'b0,
        SERVE = 1'b1
    } state_t;

    typedef struct packed {
        logic                  we;
        logic [DEF_ADDR_W-1:0] addr;
        logic                  wdata;
    } req_t;

endpackage

// File: rtl/bit_mem_ctrl_rr_arbiter.sv
// Combinational round-robin arbiter: first active request after ptr wins.
module rr_arbiter
    import bit_mem_pkg::*;
#(
    parameter int NREQ  = DEF_NREQ,
    parameter int IDX_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] ptr,
    output logic [NREQ-1:0]  gnt,
    output logic [IDX_W-1:0] gnt_idx
);

    // Scan offsets from farthest to nearest so the nearest active request overrides.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        for (int k = NREQ; k >= 1; k--) begin
            for (int j = 0; j < NREQ; j++) begin
                if (req[j] && (j == (int'(ptr) + k) % NREQ)) begin
                    gnt     = '0;
                    gnt[j]  = 1'b1;
                    gnt_idx = IDX_W'(j);
                end
            end
        end
    end

endmodule

// File: rtl/bit_mem_ctrl.sv
// Owns the single port of a bit memory: clears it after reset, then serves
// one round-robin-arbitrated request per cycle with a registered response.
//
// state | meaning
// INIT  | writing 0 to every address, requests held off
// SERVE | arbitrating requests, one access per cycle
module bit_mem_ctrl
    import bit_mem_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DEPTH  = 1 << ADDR_W,
    parameter int NREQ   = DEF_NREQ
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREQ-1:0]        req_valid,
    output logic [NREQ-1:0]        req_ready,
    input  logic [NREQ-1:0]        req_we,
    input  logic [NREQ*ADDR_W-1:0] req_addr,
    input  logic [NREQ-1:0]        req_wdata,
    output logic [NREQ-1:0]        rsp_valid,
    output logic                   rsp_rdata,
    output logic                   init_done,
    output logic                   mem_we,
    output logic [ADDR_W-1:0]      mem_addr,
    output logic                   mem_wdata,
    input  logic                   mem_rdata
);

    localparam int IDX_W = $clog2(NREQ);

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] clr_cnt;
    logic [IDX_W-1:0]  rr_ptr;
    logic [NREQ-1:0]   gnt;
    logic [IDX_W-1:0]  gnt_idx;
    logic              clr_last;
    logic              accept;
    logic              sel_we;
    logic              sel_wdata;
    logic [ADDR_W-1:0] sel_addr;

    rr_arbiter #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_arb (
        .req     (req_valid),
        .ptr     (rr_ptr),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    always_comb begin
        sel_we    = 1'b0;
        sel_wdata = 1'b0;
        sel_addr  = '0;
        for (int j = 0; j < NREQ; j++) begin
            if (j == int'(gnt_idx)) begin
                sel_we    = req_we[j];
                sel_wdata = req_wdata[j];
                sel_addr  = req_addr[j*ADDR_W +: ADDR_W];
            end
        end
    end

    assign clr_last = (clr_cnt == ADDR_W'(DEPTH - 1));
    assign accept   = (state == SERVE) && (|req_valid);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= INIT;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            INIT:    if (clr_last) state_nxt = SERVE;
            SERVE:   state_nxt = SERVE;
            default: state_nxt = INIT;
        endcase
    end

    // Outputs are forced quiet while reset is held, even though state is already INIT.
    always_comb begin
        req_ready = '0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = 1'b0;
        if (!rst) begin
            case (state)
                INIT: begin
                    mem_we   = 1'b1;
                    mem_addr = clr_cnt;
                end
                SERVE: begin
                    if (|req_valid) begin
                        req_ready = gnt;
                        mem_we    = sel_we;
                        mem_addr  = sel_addr;
                        mem_wdata = sel_wdata;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clr_cnt   <= '0;
            rr_ptr    <= IDX_W'(NREQ - 1);
            rsp_valid <= '0;
            rsp_rdata <= 1'b0;
            init_done <= 1'b0;
        end else begin
            rsp_valid <= '0;
            if (state == INIT) begin
                clr_cnt <= clr_cnt + 1'b1;
                if (clr_last) init_done <= 1'b1;
            end
            if (accept) begin
                rr_ptr    <= gnt_idx;
                rsp_valid <= gnt;
                rsp_rdata <= mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_bit_mem_ctrl.sv
// Directed bench for bit_mem_ctrl with a 32x1 bit memory model on the mem_* port.
module tb_bit_mem_ctrl;
    import bit_mem_pkg::*;

    localparam int AW = DEF_ADDR_W;
    localparam int N  = DEF_NREQ;
    localparam int D  = DEF_DEPTH;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [N-1:0]  req_valid = '0;
    logic [N-1:0]  req_ready, req_we, req_wdata, rsp_valid;
    logic [N*AW-1:0] req_addr;
    logic          rsp_rdata, init_done, mem_we, mem_wdata, mem_rdata;
    logic [AW-1:0] mem_addr;

    req_t          rq [N];
    logic [D-1:0]  mem_bits = '1;
    bit            exp_rr [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    int            errors = 0;
    int            checks = 0;

    always #5 clk = ~clk;

    for (genvar j = 0; j < N; j++) begin : g_req
        assign req_we[j]              = rq[j].we;
        assign req_addr[j*AW +: AW]   = rq[j].addr;
        assign req_wdata[j]           = rq[j].wdata;
    end

    assign mem_rdata = mem_bits[mem_addr];
    always @(posedge clk) if (mem_we) mem_bits[mem_addr] <= mem_wdata;

    bit_mem_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .init_done (init_done),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic settle;
        #2;
    endtask

    task automatic idle;
        for (int j = 0; j < N; j++) rq[j] = '0;
        req_valid = '0;
    endtask

    task automatic set_req(input int r, input bit we, input int addr, input bit wd);
        rq[r].we    = we;
        rq[r].addr  = AW'(addr);
        rq[r].wdata = wd;
        req_valid[r] = 1'b1;
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_ready"}, req_ready, 0);
        chk({tag, "_rsp_valid"}, rsp_valid, 0);
        chk({tag, "_rsp_rdata"}, rsp_rdata, 0);
        chk({tag, "_init_done"}, init_done, 0);
        chk({tag, "_mem_we"}, mem_we, 0);
        chk({tag, "_mem_addr"}, mem_addr, 0);
        chk({tag, "_mem_wdata"}, mem_wdata, 0);
    endtask

    task automatic init_cycles(input int n);
        for (int c = 0; c < n; c++) begin
            settle;
            chk("clr_we", mem_we, 1);
            chk("clr_addr", mem_addr, c);
            chk("clr_wdata", mem_wdata, 0);
            chk("clr_init_done", init_done, 0);
            chk("clr_ready", req_ready, 0);
            cyc;
        end
    endtask

    task automatic do_req(input int r, input bit we, input int addr, input bit wd, input bit exp);
        set_req(r, we, addr, wd);
        settle;
        chk("grant", req_ready, 1 << r);
        chk("req_mem_we", mem_we, we);
        chk("req_mem_addr", mem_addr, addr);
        if (we) chk("req_mem_wdata", mem_wdata, wd);
        cyc;
        idle;
        chk("rsp_valid", rsp_valid, 1 << r);
        chk("rsp_rdata", rsp_rdata, exp);
        settle;
        chk("idle_ready", req_ready, 0);
        chk("idle_mem_we", mem_we, 0);
        chk("idle_mem_addr", mem_addr, 0);
        cyc;
        chk("rsp_pulse_end", rsp_valid, 0);
    endtask

    initial begin
        idle;
        rst = 1'b1;
        cyc;
        cyc;
        chk_quiet("rst0");
        rst = 1'b0;

        // Clear sequence, then everything reads back 0
        init_cycles(32);
        settle;
        chk("init_done_hi", init_done, 1);
        chk("serve_idle_we", mem_we, 0);
        chk("serve_idle_addr", mem_addr, 0);
        chk("serve_idle_ready", req_ready, 0);
        do_req(0, 1'b0, 0, 1'b0, 1'b0);
        do_req(0, 1'b0, 13, 1'b0, 1'b0);
        do_req(0, 1'b0, 31, 1'b0, 1'b0);

        // Read-before-write, then read of the new value
        do_req(0, 1'b1, 31, 1'b1, 1'b0);
        do_req(0, 1'b0, 31, 1'b0, 1'b1);
        do_req(1, 1'b0, 5, 1'b0, 1'b0);

        // Contention: grants alternate starting with req0
        set_req(0, 1'b0, 5, 1'b0);
        set_req(1, 1'b1, 5, 1'b1);
        for (int k = 0; k <= 6; k++) begin
            if (k > 0) begin
                chk("rr_rsp_valid", rsp_valid, 1 << ((k - 1) % 2));
                chk("rr_rsp_rdata", rsp_rdata, exp_rr[k-1]);
            end
            if (k < 6) begin
                settle;
                chk("rr_grant", req_ready, 1 << (k % 2));
            end else begin
                idle;
            end
            cyc;
        end
        chk("rr_rsp_end", rsp_valid, 0);

        // Back-to-back write then read of addr 7
        set_req(0, 1'b1, 7, 1'b1);
        settle;
        chk("b2b_grant_w", req_ready, 1);
        cyc;
        chk("b2b_rsp_w", rsp_valid, 1);
        chk("b2b_rdata_w", rsp_rdata, 0);
        set_req(0, 1'b0, 7, 1'b0);
        settle;
        chk("b2b_grant_r", req_ready, 1);
        chk("b2b_mem_we_r", mem_we, 0);
        cyc;
        chk("b2b_rsp_r", rsp_valid, 1);
        chk("b2b_rdata_r", rsp_rdata, 1);
        idle;
        cyc;
        chk("b2b_rsp_end", rsp_valid, 0);

        // Reset one cycle after a SERVE accept drops the pending response
        set_req(1, 1'b1, 9, 1'b1);
        settle;
        chk("pre_rst_grant", req_ready, 2);
        cyc;
        set_req(0, 1'b0, 9, 1'b0);
        rst = 1'b1;
        #1;
        chk_quiet("rst_serve");
        cyc;
        chk_quiet("rst_serve_hold");
        rst = 1'b0;
        idle;

        // Reset at cycle 10 of the clear restarts it from address 0
        init_cycles(10);
        rst = 1'b1;
        #1;
        chk_quiet("rst_init");
        cyc;
        rst = 1'b0;

        // Request held through the whole clear is accepted at cycle 32
        set_req(0, 1'b0, 31, 1'b0);
        init_cycles(32);
        settle;
        chk("late_init_done", init_done, 1);
        chk("late_grant", req_ready, 1);
        chk("late_mem_addr", mem_addr, 31);
        cyc;
        idle;
        chk("late_rsp_valid", rsp_valid, 1);
        chk("late_rsp_rdata", rsp_rdata, 0);
        cyc;
        chk("late_rsp_end", rsp_valid, 0);
        do_req(0, 1'b0, 5, 1'b0, 1'b0);
        do_req(0, 1'b0, 7, 1'b0, 1'b0);
        do_req(1, 1'b0, 9, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
